// File: rtl/alu_pkg.sv
// Shared definitions for the digit-serial ALU: op encoding, FSM states and
// default operand/digit widths.
package alu_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_DIGIT = 8;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_SLT);
   endfunction

   // SUB and SLT both evaluate a + ~b + 1 across the chunk chain.
   function automatic logic op_inverts_b(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// One DIGIT-bit slice of the ALU datapath; carry is chained externally
// through a register so the same slice serves every chunk.
module alu_digit_slice
   import alu_pkg::*;
#(
   parameter int unsigned DIGIT = DEF_DIGIT
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic [2:0]       op,
   input  logic             cin,
   output logic [DIGIT-1:0] r_d,
   output logic             cout
);

   logic [DIGIT-1:0] b_eff;
   logic [DIGIT:0]   sum;

   always_comb begin
      b_eff = op_inverts_b(op) ? ~b_d : b_d;
      sum   = {1'b0, a_d} + {1'b0, b_eff} + (DIGIT+1)'(cin);
      r_d   = '0;
      cout  = 1'b0;
      case (op)
         OP_AND: r_d = a_d & b_d;
         OP_OR:  r_d = a_d | b_d;
         OP_ADD, OP_SUB, OP_SLT: begin
            r_d  = sum[DIGIT-1:0];
            cout = sum[DIGIT];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_serial_responder.sv
// Digit-serial ALU responder: accepts (a, b, op) over valid/ready, walks the
// operands one DIGIT-wide chunk per cycle, and returns z/zero/err.
module alu_serial_responder
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DIGIT = DEF_DIGIT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_z,
   output logic             rsp_zero,
   output logic             rsp_err
);

   localparam int unsigned NCHUNK = WIDTH / DIGIT;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [2:0]       op_q;
   logic             carry;

   logic [DIGIT-1:0] a_d;
   logic [DIGIT-1:0] b_d;
   logic [DIGIT-1:0] r_d;
   logic             cout;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] fin_z;
   logic             fin_err;
   int unsigned      base;

   assign req_ready = (state == IDLE);

   // Select the current chunk and merge its result into the partial result.
   always_comb begin
      base     = int'(cnt) * DIGIT;
      a_d      = a_q[base +: DIGIT];
      b_d      = b_q[base +: DIGIT];
      res_next = res_q;
      res_next[base +: DIGIT] = r_d;
   end

   alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
      .a_d  (a_d),
      .b_d  (b_d),
      .op   (op_q),
      .cin  (carry),
      .r_d  (r_d),
      .cout (cout)
   );

   // Final result as seen on the last chunk; SLT uses the last carry-out only.
   always_comb begin
      fin_err = !op_legal(op_q);
      if (fin_err)
         fin_z = '0;
      else if (op_q == OP_SLT)
         fin_z = {{(WIDTH-1){1'b0}}, ~cout};
      else
         fin_z = res_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         op_q      <= OP_AND;
         carry     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_z     <= '0;
         rsp_zero  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_q   <= req_a;
                  b_q   <= req_b;
                  op_q  <= req_op;
                  cnt   <= '0;
                  res_q <= '0;
                  carry <= op_inverts_b(req_op);
                  state <= CALC;
               end
            end
            CALC: begin
               res_q <= res_next;
               carry <= cout;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  rsp_z     <= fin_z;
                  rsp_zero  <= (fin_z == '0);
                  rsp_err   <= fin_err;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_responder.sv
// Randomized self-checking bench for alu_serial_responder against a
// transaction-level reference model.
module tb_alu_serial_responder;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned DIGIT  = 8;
   localparam int unsigned NCHUNK = WIDTH / DIGIT;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [WIDTH-1:0] req_a = '0;
   logic [WIDTH-1:0] req_b = '0;
   logic [2:0]       req_op = 3'b000;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_z;
   logic             rsp_zero;
   logic             rsp_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_serial_responder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_z     (rsp_z),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err)
   );

   function automatic logic [WIDTH-1:0] ref_z(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b111:  return (a < b) ? WIDTH'(1) : '0;
         default: return '0;
      endcase
   endfunction

   function automatic logic ref_err(input logic [2:0] op);
      return !(op == 3'b000 || op == 3'b001 || op == 3'b010 ||
               op == 3'b110 || op == 3'b111);
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a request is busy for NCHUNK edges, then holds its result
   // until the consumer takes it.
   bit               m_busy = 1'b0;
   bit               m_valid = 1'b0;
   int               m_left = 0;
   logic [WIDTH-1:0] m_z = '0;
   logic             m_zero = 1'b0;
   logic             m_err = 1'b0;
   logic [WIDTH-1:0] p_z = '0;
   logic             p_err = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
         m_z = '0; m_zero = 1'b0; m_err = 1'b0;
      end else if (m_valid) begin
         if (rsp_ready) m_valid = 1'b0;
      end else if (m_busy) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_busy = 1'b0; m_valid = 1'b1;
            m_z = p_z; m_zero = (p_z == '0); m_err = p_err;
         end
      end else if (req_valid) begin
         m_busy = 1'b1; m_left = NCHUNK;
         p_z = ref_z(req_a, req_b, req_op);
         p_err = ref_err(req_op);
      end
   end

   always @(negedge clk) begin
      check_bit("req_ready", req_ready, !m_busy && !m_valid);
      check_bit("rsp_valid", rsp_valid, m_valid);
      if (m_valid || !rst_n) begin
         check("rsp_z", rsp_z, m_z);
         check_bit("rsp_zero", rsp_zero, m_zero);
         check_bit("rsp_err", rsp_err, m_err);
      end
   end

   task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] op, input int hold, input bit pin,
                          input logic [WIDTH-1:0] ez, input logic ezero,
                          input logic eerr);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
      check_bit("ready_wait", req_ready, 1'b1);
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = $urandom; req_b = $urandom; req_op = 3'($urandom);
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("latency", WIDTH'(n), WIDTH'(NCHUNK));
      if (pin) begin
         check("lit_z", rsp_z, ez);
         check_bit("lit_zero", rsp_zero, ezero);
         check_bit("lit_err", rsp_err, eerr);
      end
      if (hold > 0) begin
         req_valid = 1'b1;
         repeat (hold) begin @(posedge clk); #1; end
         req_valid = 1'b0;
         check_bit("bp_valid", rsp_valid, 1'b1);
         check_bit("bp_ready", req_ready, 1'b0);
         if (pin) check("bp_z", rsp_z, ez);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check_bit("valid_drop", rsp_valid, 1'b0);
   endtask

   logic [2:0] ops [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111,
                           3'b011, 3'b100, 3'b101};

   initial begin
      logic [WIDTH-1:0] ra, rb;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Pin the reference model to hand-derived values.
      check("model_add", ref_z(32'h000000FF, 32'h1, 3'b010), 32'h00000100);
      check("model_sub", ref_z(32'h00010000, 32'h1, 3'b110), 32'h0000FFFF);
      check("model_slt_lt", ref_z(32'd5, 32'd7, 3'b111), 32'd1);
      check("model_slt_uns", ref_z(32'hFFFFFFFF, 32'd1, 3'b111), 32'd0);
      check("model_and", ref_z(32'hF0F0F0F0, 32'hFF00FF00, 3'b000), 32'hF000F000);
      check("model_or", ref_z(32'hF0F0F0F0, 32'hFF00FF00, 3'b001), 32'hFFF0FFF0);
      check_bit("model_illegal", ref_err(3'b011), 1'b1);

      run_txn(32'h000000FF, 32'h00000001, 3'b010, 0, 1, 32'h00000100, 1'b0, 1'b0);
      run_txn(32'h00010000, 32'h00000001, 3'b110, 0, 1, 32'h0000FFFF, 1'b0, 1'b0);
      run_txn(32'h12345678, 32'h12345678, 3'b110, 0, 1, 32'h0, 1'b1, 1'b0);
      run_txn(32'd5, 32'd7, 3'b111, 0, 1, 32'd1, 1'b0, 1'b0);
      run_txn(32'hFFFFFFFF, 32'd1, 3'b111, 0, 1, 32'd0, 1'b1, 1'b0);
      run_txn(32'h80000000, 32'h80000000, 3'b111, 0, 1, 32'd0, 1'b1, 1'b0);
      run_txn(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 0, 1, 32'hF000F000, 1'b0, 1'b0);
      run_txn(32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 3, 1, 32'hFFF0FFF0, 1'b0, 1'b0);
      run_txn(32'hDEADBEEF, 32'h12345678, 3'b011, 3, 1, 32'h0, 1'b1, 1'b1);

      // Abandon a transaction in its second compute cycle.
      req_a = 32'd100; req_b = 32'd200; req_op = 3'b010; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_bit("rst_mid_valid", rsp_valid, 1'b0);
      check_bit("rst_mid_ready", req_ready, 1'b1);
      check("rst_mid_z", rsp_z, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (NCHUNK + 2) begin
         @(posedge clk); #1;
         check_bit("no_orphan_rsp", rsp_valid, 1'b0);
      end
      run_txn(32'd3, 32'd4, 3'b010, 0, 1, 32'd7, 1'b0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = $urandom; rb = ra; end
            2: begin ra = WIDTH'($urandom_range(0, 15)); rb = WIDTH'($urandom_range(0, 15)); end
            default: begin ra = 32'hFFFFFFFF; rb = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h1; end
         endcase
         run_txn(ra, rb, ops[$urandom_range(0, 7)], int'($urandom_range(0, 3)),
                 1'b0, '0, 1'b0, 1'b0);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
